// File: rtl/burst_rr_arbiter.sv
// Burst-locked round-robin arbiter: one requester owns the shared port from its first beat
// until last, abandon, or MAX_BEATS beats; the releasing edge rearbitrates without a dead cycle.
module burst_rr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int MAX_BEATS = 8,
  localparam int ID_W     = $clog2(N_REQ),
  localparam int CNT_W    = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] last,
  input  logic             ready,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic [ID_W-1:0]  gnt_id,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             burst_trunc
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] w_gnt_nxt;
  logic             r_gnt_valid;
  logic             w_gnt_valid_nxt;
  logic [ID_W-1:0]  r_gnt_id;
  logic [ID_W-1:0]  w_gnt_id_nxt;
  logic [CNT_W-1:0] r_beat_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_trunc;
  logic             w_trunc_nxt;
  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  w_ptr_nxt;

  logic             w_owner_req;
  logic             w_owner_last;
  logic             w_beat;
  logic             w_cnt_full;
  logic             w_done;
  logic             w_force;
  logic             w_abandon;
  logic             w_release;
  logic [N_REQ-1:0] w_mask;
  logic [N_REQ-1:0] w_cand;
  logic [ID_W-1:0]  w_arb_ptr;
  logic [ID_W-1:0]  w_win;

  // First set bit of cand searching ptr+1, ptr+2, ... wrapping, ending at ptr.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] cand,
                                               input logic [ID_W-1:0]  ptr);
    logic [ID_W-1:0] win;
    logic            found;
    int              idx;
    win   = '0;
    found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (!found && cand[ID_W'(idx)]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
    return win;
  endfunction

  function automatic logic [N_REQ-1:0] to_onehot(input logic [ID_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  always_comb begin
    w_owner_req  = req[r_gnt_id];
    w_owner_last = last[r_gnt_id];
    w_beat       = (r_state == S_OWN) && w_owner_req && ready;
    w_cnt_full   = (r_beat_cnt == CNT_W'(MAX_BEATS - 1));
    // Completion wins over truncation when both land on the same beat.
    w_done       = w_beat && w_owner_last;
    w_force      = w_beat && w_cnt_full && !w_owner_last;
    w_abandon    = (r_state == S_OWN) && !w_owner_req;
    w_release    = w_done || w_force || w_abandon;
  end

  // The releasing owner is excluded from the same-edge rearbitration.
  always_comb begin
    w_mask           = '0;
    w_mask[r_gnt_id] = 1'b1;
    if (r_state == S_OWN) begin
      w_cand    = req & ~w_mask;
      w_arb_ptr = r_gnt_id;
    end else begin
      w_cand    = req;
      w_arb_ptr = r_ptr;
    end
    w_win = rr_pick(w_cand, w_arb_ptr);
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_gnt_nxt    = r_gnt;
    w_gnt_id_nxt = r_gnt_id;
    w_cnt_nxt    = r_beat_cnt;
    w_ptr_nxt    = r_ptr;
    w_trunc_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|w_cand) begin
          w_state_nxt  = S_OWN;
          w_gnt_nxt    = to_onehot(w_win);
          w_gnt_id_nxt = w_win;
          w_cnt_nxt    = '0;
        end
      end
      S_OWN: begin
        if (w_release) begin
          w_ptr_nxt   = r_gnt_id;
          w_cnt_nxt   = '0;
          w_trunc_nxt = w_force;
          if (|w_cand) begin
            w_gnt_nxt    = to_onehot(w_win);
            w_gnt_id_nxt = w_win;
          end else begin
            w_state_nxt  = S_IDLE;
            w_gnt_nxt    = '0;
            w_gnt_id_nxt = '0;
          end
        end else if (w_beat) begin
          w_cnt_nxt = r_beat_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_gnt_nxt    = '0;
        w_gnt_id_nxt = '0;
        w_cnt_nxt    = '0;
      end
    endcase
    w_gnt_valid_nxt = |w_gnt_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_gnt_id    <= '0;
      r_beat_cnt  <= '0;
      r_trunc     <= 1'b0;
      r_ptr       <= ID_W'(N_REQ - 1);
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
      r_gnt_id    <= w_gnt_id_nxt;
      r_beat_cnt  <= w_cnt_nxt;
      r_trunc     <= w_trunc_nxt;
      r_ptr       <= w_ptr_nxt;
    end
  end

  assign gnt         = r_gnt;
  assign gnt_valid   = r_gnt_valid;
  assign gnt_id      = r_gnt_id;
  assign beat_cnt    = r_beat_cnt;
  assign burst_trunc = r_trunc;

endmodule
